// File: rtl/seq_mult_pkg.sv
// Shared definitions for the iterative Booth multiplier.
//   state_t    : FSM encoding (IDLE, RUN, DONE)
//   MULT_WIDTH : operand/result width
//   MULT_ITERS : Booth iterations per product (one recoded bit per clock)
//   CNT_W      : iteration counter width
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned MULT_WIDTH = 32;
   localparam int unsigned MULT_ITERS = 32;
   localparam int unsigned CNT_W      = 6;

endpackage

// File: rtl/seq_mult_32bit_if.sv
// Start/ready handshake bundle between the execute stage and the multiplier.
//   start    : request, accepted only while the multiplier is not busy
//   A, B     : two's complement operands, captured at the accepting edge
//   result   : low WIDTH bits of A*B, held until the next accepted start
//   overflow : product does not fit in WIDTH signed bits, held like result
//   ready    : one-cycle pulse, result/overflow valid
//   busy     : multiplication in progress; the pipeline stalls on it
// master: requester (execute stage / bench); slave: the multiplier.
interface seq_mult_32bit_if
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             ready;
   logic             busy;

   modport master (
      output start, A, B,
      input  result, overflow, ready, busy
   );

   modport slave (
      input  start, A, B,
      output result, overflow, ready, busy
   );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   p_in  : partial product register {acc, multiplier bits, previous bit}
//   m     : multiplicand sign-extended by one bit
//   p_out : p_in after the add/sub/none select and an arithmetic shift right
module booth_step
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic [2*WIDTH+1:0] p_in,
   input  logic [WIDTH:0]     m,
   output logic [2*WIDTH+1:0] p_out
);

   logic [WIDTH:0] acc;

   always_comb begin
      acc = p_in[2*WIDTH+1:WIDTH+1];
      unique case (p_in[1:0])
         2'b01:   acc = p_in[2*WIDTH+1:WIDTH+1] + m;
         2'b10:   acc = p_in[2*WIDTH+1:WIDTH+1] - m;
         default: acc = p_in[2*WIDTH+1:WIDTH+1];
      endcase
      // Arithmetic shift of {acc, p_in[WIDTH:0]}: replicate the accumulator sign.
      p_out = {acc[WIDTH], acc, p_in[WIDTH:1]};
   end

endmodule

// File: rtl/seq_mult_32bit.sv
// Iterative signed multiplier for the execute stage, radix-2 Booth, one
// recoded multiplier bit per clock; ready pulses 32 cycles after acceptance.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, discards any in-flight product
//   bus     : start/A/B request side, result/overflow/ready/busy response side
module seq_mult_32bit
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input logic           clock,
   input logic           reset_n,
   seq_mult_32bit_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MULT_ITERS - 1);

   state_t               state;
   state_t               state_nxt;
   logic [2*WIDTH+1:0]   p;
   logic [2*WIDTH+1:0]   p_step;
   logic [WIDTH:0]       m;
   logic [CNT_W-1:0]     count;
   logic                 accept;
   logic                 last_iter;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .p_in  (p),
      .m     (m),
      .p_out (p_step)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_iter = 1'b0;
      unique case (state)
         IDLE: begin
            accept = bus.start;
            if (bus.start) state_nxt = RUN;
         end
         RUN: begin
            last_iter = (count == LAST);
            if (count == LAST) state_nxt = DONE;
         end
         DONE: begin
            accept    = bus.start;
            state_nxt = bus.start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         p            <= '0;
         m            <= '0;
         count        <= '0;
         bus.result   <= '0;
         bus.overflow <= 1'b0;
         bus.ready    <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         // ready/busy are registered copies of the next state so no output
         // depends combinationally on start/A/B.
         bus.ready <= (state_nxt == DONE);
         bus.busy  <= (state_nxt == RUN);
         if (accept) begin
            p     <= {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
            m     <= {bus.A[WIDTH-1], bus.A};
            count <= '0;
         end else if (state == RUN) begin
            p     <= p_step;
            count <= count + CNT_W'(1);
            if (last_iter) begin
               // Product is p_step[2W:1]; its bits [2W-1:W-1] must all match.
               bus.result   <= p_step[WIDTH:1];
               bus.overflow <= ~(&p_step[2*WIDTH:WIDTH] | ~|p_step[2*WIDTH:WIDTH]);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_mult_32bit.sv
module tb_seq_mult_32bit;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   logic clock;
   logic reset_n;
   int unsigned n_tests;
   int unsigned n_fail;
   exp_t sb[$];
   exp_t mon_e;

   seq_mult_32bit_if #(.WIDTH(32)) mif ();

   seq_mult_32bit #(.WIDTH(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (mif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: full signed 64-bit product, overflow when it leaves int32 range.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sbv;
      longint prod;
      exp_t e;
      sa    = longint'($signed(a));
      sbv   = longint'($signed(b));
      prod  = sa * sbv;
      e.res = prod[31:0];
      e.ovf = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corners [5];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'hFFFF_FFFF;
      corners[3] = 32'h7FFF_FFFF;
      corners[4] = 32'h8000_0000;
      if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
      return $urandom;
   endfunction

   // Monitor: every ready pulse consumes the oldest expected product.
   always @(negedge clock) begin
      if (reset_n && mif.ready) begin
         if (sb.size() == 0) begin
            check("spurious_ready", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", 64'(mif.result), 64'(mon_e.res));
            check("overflow", 64'(mif.overflow), 64'(mon_e.ovf));
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit timing);
      int unsigned lat;
      int unsigned busy_cnt;
      bit got;
      @(negedge clock);
      mif.A     = a;
      mif.B     = b;
      mif.start = 1'b1;
      sb.push_back(model(a, b));
      @(posedge clock);
      #1;
      mif.start = 1'b0;
      mif.A     = $urandom;
      mif.B     = $urandom;
      lat       = 0;
      busy_cnt  = mif.busy ? 1 : 0;
      got       = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clock);
         #1;
         lat++;
         if (mif.ready) got = 1'b1;
         else if (mif.busy) busy_cnt++;
      end
      if (!got) check("ready_timeout", 64'(lat), 64'd32);
      if (timing) begin
         check("latency", 64'(lat), 64'd32);
         check("busy_cycles", 64'(busy_cnt), 64'd32);
         check("busy_low_at_ready", 64'(mif.busy), 64'd0);
      end
   endtask

   task automatic drain();
      int unsigned w;
      w = 0;
      while (sb.size() != 0 && w < 80) begin
         @(posedge clock);
         w++;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int unsigned last_rdy;
      bit seen;
      n_tests   = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      mif.start = 1'b0;
      mif.A     = '0;
      mif.B     = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_result", 64'(mif.result), 64'd0);
      check("rst_overflow", 64'(mif.overflow), 64'd0);
      check("rst_ready", 64'(mif.ready), 64'd0);
      check("rst_busy", 64'(mif.busy), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Directed vectors, with latency and busy-length checks.
      run_op(32'd3, 32'd5, 1'b1);
      run_op(32'hFFFF_FFF9, 32'd6, 1'b1);
      run_op(32'h8000_0000, 32'd1, 1'b1);
      run_op(32'h0001_0000, 32'h0001_0000, 1'b1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
      drain();

      // start held high with operands changing every cycle.
      seen     = 1'b0;
      last_rdy = 0;
      for (int c = 0; c < 4 * 33 + 5; c++) begin
         @(negedge clock);
         if (mif.ready) begin
            if (seen) check("ready_spacing", 64'(c - last_rdy), 64'd33);
            seen     = 1'b1;
            last_rdy = c;
         end
         mif.A     = pick();
         mif.B     = pick();
         mif.start = 1'b1;
         if (!mif.busy) sb.push_back(model(mif.A, mif.B));
      end
      @(negedge clock);
      mif.start = 1'b0;
      drain();

      // Asynchronous reset mid-run discards the operation.
      @(negedge clock);
      mif.A     = 32'd7;
      mif.B     = 32'd9;
      mif.start = 1'b1;
      sb.push_back(model(32'd7, 32'd9));
      @(posedge clock);
      #1;
      mif.start = 1'b0;
      repeat (15) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_result", 64'(mif.result), 64'd0);
      check("arst_overflow", 64'(mif.overflow), 64'd0);
      check("arst_ready", 64'(mif.ready), 64'd0);
      check("arst_busy", 64'(mif.busy), 64'd0);
      sb.delete();
      @(negedge clock);
      reset_n = 1'b1;
      repeat (40) @(posedge clock);
      #1;
      check("post_rst_busy", 64'(mif.busy), 64'd0);
      run_op(32'd2, 32'd2, 1'b1);

      // Randomized products including corner operands.
      for (int i = 0; i < 1000; i++) run_op(pick(), pick(), 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
